pc_sequencer: RTL and testbench

Program-counter sequencer for the core's fetch stage. It owns the PC register and a small return-address stack, and selects the next PC each cycle from increment, absolute jump, taken branch, call or return. Branch/jump targets come from the existing 16-entry target lookup table: the sequencer drives its index and consumes the D-bit target. It also provides start/halt/done control for the top level.

---
 rtl/pc_seq_pkg.sv | 13 +
 rtl/ras_stack.sv | 42 ++++
 rtl/pc_sequencer.sv | 106 ++++++++++
 tb/tb_pc_sequencer.sv | 200 ++++++++++++++++++++
 4 files changed

// File: rtl/pc_seq_pkg.sv
// rtl/pc_seq_pkg.sv - shared types and defaults for the program-counter sequencer
package pc_seq_pkg;

    localparam int DEF_D         = 10;
    localparam int DEF_RAS_DEPTH = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        HALT = 2'd2
    } state_t;

endpackage

// File: rtl/ras_stack.sv
// rtl/ras_stack.sv - return-address LIFO; push when full and pop when empty are no-ops
module ras_stack
    import pc_seq_pkg::*;
#(
    parameter int D     = DEF_D,
    parameter int DEPTH = DEF_RAS_DEPTH
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         push,
    input  logic         pop,
    input  logic [D-1:0] wdata,
    output logic [D-1:0] rdata,
    output logic         full,
    output logic         empty
);

    localparam int AW = $clog2(DEPTH);
    localparam int PW = AW + 1;

    logic [D-1:0]  mem [DEPTH];
    logic [PW-1:0] ptr;
    logic [AW-1:0] top_idx;

    assign full    = (ptr == PW'(DEPTH));
    assign empty   = (ptr == '0);
    assign top_idx = AW'(ptr - PW'(1));
    assign rdata   = mem[top_idx];

    // Entries are not cleared on reset; an empty pointer makes them unreachable.
    always_ff @(posedge clk) begin
        if (reset) begin
            ptr <= '0;
        end else if (pop && !empty) begin
            ptr <= ptr - PW'(1);
        end else if (push && !full) begin
            mem[ptr[AW-1:0]] <= wdata;
            ptr              <= ptr + PW'(1);
        end
    end

endmodule

// File: rtl/pc_sequencer.sv
// rtl/pc_sequencer.sv - fetch-stage PC register, next-PC select and start/halt control
module pc_sequencer
    import pc_seq_pkg::*;
#(
    parameter int D         = DEF_D,
    parameter int RAS_DEPTH = DEF_RAS_DEPTH
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         start,
    input  logic         stall,
    input  logic         halt,
    input  logic         jump,
    input  logic         branch,
    input  logic         cond,
    input  logic         call,
    input  logic         ret,
    input  logic [3:0]   idx,
    output logic [3:0]   lut_addr,
    input  logic [D-1:0] lut_target,
    output logic [D-1:0] pc,
    output logic         running,
    output logic         done,
    output logic         ras_err
);

    state_t       state;
    logic         advance;
    logic         do_push;
    logic         do_pop;
    logic [D-1:0] pc_inc;
    logic [D-1:0] ras_rdata;
    logic         ras_full;
    logic         ras_empty;

    assign lut_addr = idx;
    assign pc_inc   = pc + D'(1);
    assign advance  = (state == RUN) && !stall && !halt;
    // ret outranks call, so a simultaneous call never pushes.
    assign do_pop   = advance && ret;
    assign do_push  = advance && !ret && call;

    ras_stack #(
        .D     (D),
        .DEPTH (RAS_DEPTH)
    ) u_ras (
        .clk   (clk),
        .reset (reset),
        .push  (do_push),
        .pop   (do_pop),
        .wdata (pc_inc),
        .rdata (ras_rdata),
        .full  (ras_full),
        .empty (ras_empty)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= IDLE;
            pc      <= '0;
            running <= 1'b0;
            done    <= 1'b0;
            ras_err <= 1'b0;
        end else begin
            case (state)
                IDLE, HALT: begin
                    if (start) begin
                        state   <= RUN;
                        pc      <= '0;
                        running <= 1'b1;
                        done    <= 1'b0;
                    end
                end
                RUN: begin
                    if (!stall) begin
                        if (halt) begin
                            state   <= HALT;
                            running <= 1'b0;
                            done    <= 1'b1;
                        end else if (ret) begin
                            if (ras_empty) begin
                                ras_err <= 1'b1;
                                pc      <= pc_inc;
                            end else begin
                                pc <= ras_rdata;
                            end
                        end else if (call) begin
                            if (ras_full) ras_err <= 1'b1;
                            pc <= lut_target;
                        end else if (jump || (branch && cond)) begin
                            pc <= lut_target;
                        end else begin
                            pc <= pc_inc;
                        end
                    end
                end
                default: begin
                    state   <= IDLE;
                    running <= 1'b0;
                    done    <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_pc_sequencer.sv
// tb/tb_pc_sequencer.sv - self-checking bench for pc_sequencer against a behavioural model
module tb_pc_sequencer;

    localparam int D     = 10;
    localparam int DEPTH = 4;
    localparam int MODV  = 1 << D;

    logic         clk = 1'b0;
    logic         reset, start, stall, halt, jump, branch, cond, call, ret;
    logic [3:0]   idx;
    logic [3:0]   lut_addr;
    logic [D-1:0] lut_target;
    logic [D-1:0] pc;
    logic         running, done, ras_err;

    logic [D-1:0] lut [16];

    int checks   = 0;
    int failures = 0;

    int m_state;
    int m_pc;
    int m_err;
    int m_stack [$];

    always #5 clk = ~clk;

    assign lut_target = lut[lut_addr];

    pc_sequencer #(.D(D), .RAS_DEPTH(DEPTH)) dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .stall      (stall),
        .halt       (halt),
        .jump       (jump),
        .branch     (branch),
        .cond       (cond),
        .call       (call),
        .ret        (ret),
        .idx        (idx),
        .lut_addr   (lut_addr),
        .lut_target (lut_target),
        .pc         (pc),
        .running    (running),
        .done       (done),
        .ras_err    (ras_err)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic clear_in();
        reset = 0; start = 0; stall = 0; halt = 0; jump = 0;
        branch = 0; cond = 0; call = 0; ret = 0; idx = 0;
    endtask

    // Reference behaviour: state 0=idle, 1=run, 2=halt; the stack is a plain queue.
    function automatic void model_step();
        if (reset) begin
            m_state = 0; m_pc = 0; m_err = 0; m_stack.delete();
        end else if (m_state == 0 || m_state == 2) begin
            if (start) begin m_state = 1; m_pc = 0; end
        end else if (!stall) begin
            if (halt) m_state = 2;
            else if (ret) begin
                if (m_stack.size() == 0) begin m_err = 1; m_pc = (m_pc + 1) % MODV; end
                else m_pc = m_stack.pop_back();
            end else if (call) begin
                if (m_stack.size() == DEPTH) m_err = 1;
                else m_stack.push_back((m_pc + 1) % MODV);
                m_pc = int'(lut[idx]);
            end else if (jump || (branch && cond)) m_pc = int'(lut[idx]);
            else m_pc = (m_pc + 1) % MODV;
        end
    endfunction

    task automatic tick();
        #1;
        check("lut_addr", 32'(lut_addr), 32'(idx));
        @(posedge clk);
        model_step();
        @(negedge clk);
        check("pc", 32'(pc), 32'(m_pc));
        check("running", 32'(running), 32'(m_state == 1));
        check("done", 32'(done), 32'(m_state == 2));
        check("ras_err", 32'(ras_err), 32'(m_err));
    endtask

    task automatic do_jump(input int target);
        lut[15] = D'(target);
        jump = 1; idx = 15; tick(); jump = 0; idx = 0;
    endtask

    initial begin
        int exp_ret [5];
        exp_ret = '{301, 201, 101, 57, 58};
        for (int i = 0; i < 16; i++) lut[i] = D'($urandom_range(MODV - 1));
        lut[2] = 80; lut[4] = 113; lut[6] = 56;
        lut[8] = 100; lut[9] = 200; lut[10] = 300; lut[11] = 400; lut[12] = 500;

        clear_in();
        @(negedge clk);
        reset = 1; tick(); reset = 0;
        check("rst_pc", 32'(pc), 0);
        check("rst_running", 32'(running), 0);
        check("rst_done", 32'(done), 0);

        start = 1; tick(); start = 0;
        check("start_pc", 32'(pc), 0);
        check("start_running", 32'(running), 1);
        for (int i = 1; i <= 3; i++) begin
            tick();
            check("inc_pc", 32'(pc), 32'(i));
        end
        reset = 1; tick(); reset = 0;
        check("midrun_rst_pc", 32'(pc), 0);
        check("midrun_rst_running", 32'(running), 0);

        start = 1; tick(); start = 0;
        do_jump(5);
        branch = 1; cond = 1; idx = 2; tick(); branch = 0; cond = 0;
        check("branch_taken", 32'(pc), 80);
        do_jump(5);
        branch = 1; cond = 0; idx = 2; tick(); branch = 0;
        check("branch_not_taken", 32'(pc), 6);
        jump = 1; idx = 4; tick(); jump = 0;
        check("jump", 32'(pc), 113);

        do_jump(10);
        call = 1; idx = 6; tick(); call = 0;
        check("call", 32'(pc), 56);
        ret = 1; tick(); ret = 0;
        check("ret", 32'(pc), 11);

        do_jump(56);
        for (int i = 0; i < 5; i++) begin
            call = 1; idx = 4'(8 + i); tick();
        end
        call = 0;
        check("overflow_err", 32'(ras_err), 1);
        check("overflow_jump", 32'(pc), 500);
        for (int i = 0; i < 5; i++) begin
            ret = 1; tick();
            check("lifo_ret", 32'(pc), 32'(exp_ret[i]));
        end
        ret = 0;

        stall = 1; halt = 1; jump = 1; idx = 4; tick();
        check("stall_pc", 32'(pc), 58);
        check("stall_running", 32'(running), 1);
        stall = 0; tick(); halt = 0; jump = 0;
        check("halt_pc", 32'(pc), 58);
        check("halt_done", 32'(done), 1);
        start = 1; tick(); start = 0;
        check("restart_pc", 32'(pc), 0);
        check("restart_done", 32'(done), 0);
        check("restart_err_kept", 32'(ras_err), 1);

        reset = 1; tick(); reset = 0;
        start = 1; tick(); start = 0;
        do_jump(10);
        call = 1; idx = 6; tick();
        ret = 1; tick(); call = 0;
        check("call_ret_pc", 32'(pc), 11);
        check("call_ret_err", 32'(ras_err), 0);
        tick(); ret = 0;
        check("no_push_err", 32'(ras_err), 1);
        check("no_push_pc", 32'(pc), 12);

        do_jump(MODV - 1);
        tick();
        check("wrap", 32'(pc), 0);

        for (int n = 0; n < 1500; n++) begin
            reset  = ($urandom_range(199) == 0);
            start  = ($urandom_range(7) == 0);
            stall  = ($urandom_range(5) == 0);
            halt   = ($urandom_range(39) == 0);
            ret    = ($urandom_range(5) == 0);
            call   = ($urandom_range(5) == 0);
            jump   = ($urandom_range(7) == 0);
            branch = ($urandom_range(4) == 0);
            cond   = 1'($urandom_range(1));
            idx    = 4'($urandom_range(15));
            if ($urandom_range(15) == 0)
                lut[$urandom_range(15)] = ($urandom_range(3) == 0) ? D'(MODV - 1) : D'($urandom_range(MODV - 1));
            tick();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
